// File: rtl/ext_bus_pkg.sv
// Shared types for the multiplexed 8051 external bus controller.
package ext_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LATCH,
    STROBE,
    HOLD
  } state_e;

  typedef enum logic [1:0] {
    G_NONE,
    G_ROM,
    G_RD,
    G_WR
  } grant_e;

  localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/ext_bus_arb.sv
// Priority encoder choosing which requester owns the next bus cycle.
module ext_bus_arb
  import ext_bus_pkg::*;
#(
  parameter bit PRIO_DATA = 1'b1
) (
  input  logic   rom_req_i,
  input  logic   rd_req_i,
  input  logic   wr_req_i,
  output grant_e gnt_c
);

  // Write always outranks read; PRIO_DATA places the data pair above or below fetch.
  always_comb begin
    gnt_c = G_NONE;
    if (PRIO_DATA) begin
      if (wr_req_i)       gnt_c = G_WR;
      else if (rd_req_i)  gnt_c = G_RD;
      else if (rom_req_i) gnt_c = G_ROM;
    end else begin
      if (rom_req_i)      gnt_c = G_ROM;
      else if (wr_req_i)  gnt_c = G_WR;
      else if (rd_req_i)  gnt_c = G_RD;
    end
  end

endmodule

// File: rtl/ext_bus_ctrl.sv
// Multiplexed 8051 external bus controller: code fetch and xdata read/write
// become ALE / PSEN_n / RD_n / WR_n bus cycles with configurable wait states.
module ext_bus_ctrl
  import ext_bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned WAIT      = 1,
  parameter bit          PRIO_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_en,
  input  logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic              rom_ready,
  input  logic              ram_rd_en,
  input  logic [ADDR_W-1:0] ram_rd_addr,
  output logic [7:0]        ram_rd_data,
  input  logic              ram_wr_en,
  input  logic [ADDR_W-1:0] ram_wr_addr,
  input  logic [7:0]        ram_wr_data,
  output logic              ram_ready,
  output logic [7:0]        ad_o,
  output logic              ad_oe,
  input  logic [7:0]        ad_i,
  output logic [ADDR_W-9:0] a_hi,
  output logic              ale,
  output logic              psen_n,
  output logic              rd_n,
  output logic              wr_n
);

  state_e              state_q, state_d;
  grant_e              gnt_q, gnt_d, gnt_arb;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          rom_data_q, rom_data_d, rd_data_q, rd_data_d;
  logic [7:0]          ad_o_q, ad_o_d;
  logic [ADDR_W-9:0]   a_hi_q, a_hi_d;
  logic                ad_oe_q, ad_oe_d, ale_q, ale_d;
  logic                psen_n_q, psen_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic                rom_ready_q, rom_ready_d, ram_ready_q, ram_ready_d;

  ext_bus_arb #(
    .PRIO_DATA(PRIO_DATA)
  ) u_arb (
    .rom_req_i(rom_en),
    .rd_req_i (ram_rd_en),
    .wr_req_i (ram_wr_en),
    .gnt_c    (gnt_arb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= G_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rom_data_q  <= '0;
      rd_data_q   <= '0;
      ad_o_q      <= '0;
      a_hi_q      <= '0;
      ad_oe_q     <= 1'b0;
      ale_q       <= 1'b0;
      psen_n_q    <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rom_ready_q <= 1'b0;
      ram_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rom_data_q  <= rom_data_d;
      rd_data_q   <= rd_data_d;
      ad_o_q      <= ad_o_d;
      a_hi_q      <= a_hi_d;
      ad_oe_q     <= ad_oe_d;
      ale_q       <= ale_d;
      psen_n_q    <= psen_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      rom_ready_q <= rom_ready_d;
      ram_ready_q <= ram_ready_d;
    end
  end

  // Next state first, then outputs decoded from the next state so pins are registered.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rom_data_d  = rom_data_q;
    rd_data_d   = rd_data_q;
    ad_o_d      = ad_o_q;
    a_hi_d      = a_hi_q;
    ad_oe_d     = 1'b0;
    ale_d       = 1'b0;
    psen_n_d    = 1'b1;
    rd_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    rom_ready_d = 1'b0;
    ram_ready_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_arb != G_NONE) begin
          state_d = ADDR;
          gnt_d   = gnt_arb;
          wdata_d = ram_wr_data;
          case (gnt_arb)
            G_ROM:   addr_d = rom_addr;
            G_RD:    addr_d = ram_rd_addr;
            G_WR:    addr_d = ram_wr_addr;
            default: addr_d = addr_q;
          endcase
        end
      end
      ADDR:  state_d = LATCH;
      LATCH: begin
        state_d = STROBE;
        cnt_d   = WAIT_W'(WAIT);
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          if (gnt_q == G_ROM) rom_data_d = ad_i;
          if (gnt_q == G_RD)  rd_data_d  = ad_i;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      ADDR: begin
        ale_d   = 1'b1;
        ad_oe_d = 1'b1;
        ad_o_d  = addr_d[7:0];
        a_hi_d  = addr_d[ADDR_W-1:8];
      end
      LATCH: begin
        ad_oe_d = 1'b1;
        ad_o_d  = addr_d[7:0];
      end
      STROBE: begin
        psen_n_d = (gnt_d != G_ROM);
        rd_n_d   = (gnt_d != G_RD);
        wr_n_d   = (gnt_d != G_WR);
        if (gnt_d == G_WR) begin
          ad_oe_d = 1'b1;
          ad_o_d  = wdata_d;
        end
      end
      HOLD: begin
        rom_ready_d = (gnt_d == G_ROM);
        ram_ready_d = (gnt_d == G_RD) || (gnt_d == G_WR);
        if (gnt_d == G_WR) begin
          ad_oe_d = 1'b1;
          ad_o_d  = wdata_d;
        end
      end
      default: ;
    endcase
  end

  assign rom_data    = rom_data_q;
  assign rom_ready   = rom_ready_q;
  assign ram_rd_data = rd_data_q;
  assign ram_ready   = ram_ready_q;
  assign ad_o        = ad_o_q;
  assign ad_oe       = ad_oe_q;
  assign a_hi        = a_hi_q;
  assign ale         = ale_q;
  assign psen_n      = psen_n_q;
  assign rd_n        = rd_n_q;
  assign wr_n        = wr_n_q;

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Self-checking bench for ext_bus_ctrl: three instances cover
// (WAIT=1, data priority), (WAIT=1, fetch priority) and (WAIT=3, data priority).
module tb_ext_bus_ctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned NI = 3;

  typedef enum logic [1:0] {K_ROM, K_RD, K_WR} kind_e;

  typedef struct {
    int unsigned inst;
    kind_e       kind;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  adi;
    int unsigned rdy;
    logic [7:0]  rdata;
  } vec_t;

  typedef struct {
    kind_e       kind;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic          rom_en      [NI];
  logic [AW-1:0] rom_addr    [NI];
  logic [7:0]    rom_data    [NI];
  logic          rom_ready   [NI];
  logic          ram_rd_en   [NI];
  logic [AW-1:0] ram_rd_addr [NI];
  logic [7:0]    ram_rd_data [NI];
  logic          ram_wr_en   [NI];
  logic [AW-1:0] ram_wr_addr [NI];
  logic [7:0]    ram_wr_data [NI];
  logic          ram_ready   [NI];
  logic [7:0]    ad_o        [NI];
  logic          ad_oe       [NI];
  logic [7:0]    ad_i        [NI];
  logic [AW-9:0] a_hi        [NI];
  logic          ale         [NI];
  logic          psen_n      [NI];
  logic          rd_n        [NI];
  logic          wr_n        [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    ext_bus_ctrl #(
      .ADDR_W   (AW),
      .WAIT     ((gi == 2) ? 3 : 1),
      .PRIO_DATA((gi == 1) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .rom_en     (rom_en[gi]),
      .rom_addr   (rom_addr[gi]),
      .rom_data   (rom_data[gi]),
      .rom_ready  (rom_ready[gi]),
      .ram_rd_en  (ram_rd_en[gi]),
      .ram_rd_addr(ram_rd_addr[gi]),
      .ram_rd_data(ram_rd_data[gi]),
      .ram_wr_en  (ram_wr_en[gi]),
      .ram_wr_addr(ram_wr_addr[gi]),
      .ram_wr_data(ram_wr_data[gi]),
      .ram_ready  (ram_ready[gi]),
      .ad_o       (ad_o[gi]),
      .ad_oe      (ad_oe[gi]),
      .ad_i       (ad_i[gi]),
      .a_hi       (a_hi[gi]),
      .ale        (ale[gi]),
      .psen_n     (psen_n[gi]),
      .rd_n       (rd_n[gi]),
      .wr_n       (wr_n[gi])
    );
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  exp_t        sb_q[$];
  vec_t        tbl[8];

  task automatic chk(input string name, input int unsigned i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d @%0t: got 0x%0h, expected 0x%0h", name, i, $time, act, exp);
    end
  endtask

  task automatic drop(input int unsigned i, input kind_e k);
    case (k)
      K_ROM:   rom_en[i]    = 1'b0;
      K_RD:    ram_rd_en[i] = 1'b0;
      default: ram_wr_en[i] = 1'b0;
    endcase
  endtask

  task automatic raise(input int unsigned i, input kind_e k, input logic [15:0] a,
                       input logic [7:0] d);
    case (k)
      K_ROM: begin rom_en[i] = 1'b1; rom_addr[i] = a; end
      K_RD:  begin ram_rd_en[i] = 1'b1; ram_rd_addr[i] = a; end
      default: begin ram_wr_en[i] = 1'b1; ram_wr_addr[i] = a; ram_wr_data[i] = d; end
    endcase
  endtask

  task automatic chk_reset(input int unsigned i);
    chk("reset_ctl", i, 32'({psen_n[i], rd_n[i], wr_n[i], ale[i], ad_oe[i], rom_ready[i],
                             ram_ready[i]}), 32'(7'b1110000));
    chk("reset_ad_o", i, 32'(ad_o[i]), 32'h0);
    chk("reset_a_hi", i, 32'(a_hi[i]), 32'h0);
    chk("reset_rom_data", i, 32'(rom_data[i]), 32'h0);
    chk("reset_ram_rd_data", i, 32'(ram_rd_data[i]), 32'h0);
  endtask

  // Pops the scoreboard on any ready pulse and checks kind, cycle and captured data.
  task automatic sb_check(input int unsigned i, input int unsigned c, output bit seen,
                          output kind_e k);
    exp_t e;
    seen = 1'b0;
    k    = K_ROM;
    if (rom_ready[i] || ram_ready[i]) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ready inst%0d cycle %0d: rom_ready=%0b ram_ready=%0b, none expected",
                 i, c, rom_ready[i], ram_ready[i]);
      end else begin
        e    = sb_q.pop_front();
        seen = 1'b1;
        k    = e.kind;
        chk("ready_sel", i, 32'({rom_ready[i], ram_ready[i]}),
            32'({e.kind == K_ROM, e.kind != K_ROM}));
        chk("ready_cycle", i, c, e.cyc);
        if (e.kind == K_ROM)     chk("rom_data", i, 32'(rom_data[i]), 32'(e.data));
        else if (e.kind == K_RD) chk("ram_rd_data", i, 32'(ram_rd_data[i]), 32'(e.data));
      end
    end
  endtask

  task automatic sb_drain(input int unsigned i);
    chk("sb_outstanding", i, sb_q.size(), 0);
    sb_q.delete();
  endtask

  // One table vector: per-cycle pin checks from ADDR through the following IDLE cycle.
  task automatic run_vec(input vec_t v);
    int unsigned i = v.inst;
    logic [6:0]  ctl_exp;
    bit          seen;
    kind_e       k;
    @(posedge clk); #1;
    raise(i, v.kind, v.addr, v.wdata);
    ad_i[i] = ~v.adi;
    sb_q.push_back('{v.kind, v.rdata, v.rdy});
    for (int unsigned c = 1; c <= v.rdy + 1; c++) begin
      @(posedge clk); #1;
      ad_i[i] = (c == v.rdy - 1) ? v.adi : ~v.adi;
      if (c == v.rdy + 1) drop(i, v.kind);
      @(negedge clk);
      ctl_exp = {c == 1,
                 !(v.kind == K_ROM && c >= 3 && c < v.rdy),
                 !(v.kind == K_RD  && c >= 3 && c < v.rdy),
                 !(v.kind == K_WR  && c >= 3 && c < v.rdy),
                 (c <= 2) || (v.kind == K_WR && c >= 3 && c <= v.rdy),
                 v.kind == K_ROM && c == v.rdy,
                 v.kind != K_ROM && c == v.rdy};
      chk("ctl", i, 32'({ale[i], psen_n[i], rd_n[i], wr_n[i], ad_oe[i], rom_ready[i],
                         ram_ready[i]}), 32'(ctl_exp));
      if (c <= 2) chk("ad_o_addr", i, 32'(ad_o[i]), 32'(v.addr[7:0]));
      else if (v.kind == K_WR && c <= v.rdy) chk("ad_o_wdata", i, 32'(ad_o[i]), 32'(v.wdata));
      chk("a_hi", i, 32'(a_hi[i]), 32'(v.addr[15:8]));
      sb_check(i, c, seen, k);
    end
    sb_drain(i);
  endtask

  // Runs ncyc cycles, dropping each request the cycle after its ready is seen.
  task automatic watch(input int unsigned i, input int unsigned ncyc);
    bit    seen, pend;
    kind_e k, pk;
    pend = 1'b0;
    pk   = K_ROM;
    for (int unsigned c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      if (pend) drop(i, pk);
      pend = 1'b0;
      @(negedge clk);
      chk("ale_vs_strobe", i, 32'(ale[i] && !(psen_n[i] && rd_n[i] && wr_n[i])), 32'h0);
      sb_check(i, c, seen, k);
      if (seen) begin pend = 1'b1; pk = k; end
    end
    rom_en[i] = 1'b0; ram_rd_en[i] = 1'b0; ram_wr_en[i] = 1'b0;
    sb_drain(i);
  endtask

  initial begin
    rst = 1'b1;
    for (int n = 0; n < NI; n++) begin
      rom_en[n] = 1'b0; rom_addr[n] = '0; ram_rd_en[n] = 1'b0; ram_rd_addr[n] = '0;
      ram_wr_en[n] = 1'b0; ram_wr_addr[n] = '0; ram_wr_data[n] = '0; ad_i[n] = '0;
    end
    //          inst kind   addr      wdata  adi    rdy rdata
    tbl[0] = '{0, K_ROM, 16'h1234, 8'h00, 8'hA5, 5, 8'hA5};
    tbl[1] = '{0, K_WR,  16'h8001, 8'h5A, 8'h00, 5, 8'h00};
    tbl[2] = '{0, K_RD,  16'h00FF, 8'h00, 8'h3C, 5, 8'h3C};
    tbl[3] = '{1, K_RD,  16'hABCD, 8'h00, 8'h77, 5, 8'h77};
    tbl[4] = '{2, K_RD,  16'h0102, 8'h00, 8'h3C, 7, 8'h3C};
    tbl[5] = '{2, K_WR,  16'hFFFF, 8'hC3, 8'h00, 7, 8'h00};
    tbl[6] = '{1, K_ROM, 16'h0000, 8'h00, 8'hFF, 5, 8'hFF};
    tbl[7] = '{2, K_ROM, 16'h7F80, 8'h00, 8'h01, 7, 8'h01};

    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int unsigned n = 0; n < NI; n++) chk_reset(n);
    @(posedge clk); #1 rst = 1'b1;

    for (int v = 0; v < 8; v++) run_vec(tbl[v]);

    // Fetch and read together: order follows PRIO_DATA.
    @(posedge clk); #1;
    for (int unsigned n = 0; n < 2; n++) ad_i[n] = 8'h96;
    raise(0, K_ROM, 16'h2000, 8'h00); raise(0, K_RD, 16'h3000, 8'h00);
    sb_q.push_back('{K_RD, 8'h96, 5}); sb_q.push_back('{K_ROM, 8'h96, 11});
    watch(0, 14);
    @(posedge clk); #1;
    raise(1, K_ROM, 16'h2000, 8'h00); raise(1, K_RD, 16'h3000, 8'h00);
    sb_q.push_back('{K_ROM, 8'h96, 5}); sb_q.push_back('{K_RD, 8'h96, 11});
    watch(1, 14);

    // All three requesters at once, served strictly one at a time.
    @(posedge clk); #1;
    ad_i[0] = 8'h4B;
    raise(0, K_ROM, 16'h0011, 8'h00); raise(0, K_RD, 16'h0022, 8'h00);
    raise(0, K_WR, 16'h0033, 8'hE7);
    sb_q.push_back('{K_WR, 8'h00, 5}); sb_q.push_back('{K_RD, 8'h4B, 11});
    sb_q.push_back('{K_ROM, 8'h4B, 17});
    watch(0, 20);
    @(posedge clk); #1;
    ad_i[1] = 8'hD2;
    raise(1, K_ROM, 16'h0011, 8'h00); raise(1, K_RD, 16'h0022, 8'h00);
    raise(1, K_WR, 16'h0033, 8'hE7);
    sb_q.push_back('{K_ROM, 8'hD2, 5}); sb_q.push_back('{K_WR, 8'h00, 11});
    sb_q.push_back('{K_RD, 8'hD2, 17});
    watch(1, 20);

    // Reset in the middle of a WAIT=3 write strobe: no ready, clean restart.
    @(posedge clk); #1;
    raise(2, K_WR, 16'h4321, 8'h99);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("wr_n_in_strobe", 2, 32'(wr_n[2]), 32'h0);
    rst = 1'b0;
    #1;
    chk_reset(2);
    ram_wr_en[2] = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    watch(2, 10);
    run_vec(tbl[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
